burst_read_master: RTL

BURST_READ_MASTER -- requirements
Module: burst_read_master

---
 rtl/burst_read_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/burst_read_master.sv
// AXI4 read-burst master: walks num_bursts aligned INCR bursts from base_addr and
// streams each 128-bit R beat straight into a downstream FIFO.
module burst_read_master #(
  parameter int BURST_LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [15:0]  num_bursts,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  input  logic         fifo_half_full,
  output logic         fifo_write_en,
  output logic [127:0] fifo_write_data,
  output logic [2:0]   state_dbg
);

  localparam logic [31:0] STRIDE        = 32'(BURST_LEN * 16);
  localparam logic [3:0]  LAST_BEAT_CNT = 4'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    WAIT_SPACE = 3'd2,
    ADDR       = 3'd3,
    DATA       = 3'd4,
    FINISH     = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        error_q, error_d;
  logic        len_bad_q, len_bad_d;
  logic        beat;
  logic        misaligned;

  // Handshakes: a transfer happens on any rising edge where valid and ready are
  // both high; arvalid is held with a stable araddr until arready.
  assign arvalid         = (state_q == ADDR);
  assign rready          = (state_q == DATA);
  assign beat            = rvalid & rready;
  assign fifo_write_en   = beat;
  assign fifo_write_data = rdata;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign error     = error_q;
  assign araddr    = addr_q;
  assign arlen     = 8'(BURST_LEN - 1);
  assign arsize    = 3'b100;
  assign arburst   = 2'b01;
  assign state_dbg = state_q;

  assign misaligned = ((addr_q % STRIDE) != 32'd0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    len_bad_d   = len_bad_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = num_bursts;
          error_d     = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (remaining_q == 16'd0) begin
          state_d = FINISH;
        end else if (misaligned) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!fifo_half_full) state_d = ADDR;
      end
      ADDR: begin
        if (arready) begin
          beat_cnt_d = 4'd0;
          len_bad_d  = 1'b0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (rresp != 2'b00) error_d = 1'b1;
          // One length complaint per burst; after it only rlast matters.
          if (!len_bad_q && (rlast != (beat_cnt_q == LAST_BEAT_CNT))) begin
            error_d   = 1'b1;
            len_bad_d = 1'b1;
          end
          if (rlast) begin
            addr_d      = addr_q + STRIDE;
            remaining_d = remaining_q - 16'd1;
            state_d     = (remaining_q == 16'd1) ? FINISH : WAIT_SPACE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 16'd0;
      beat_cnt_q  <= 4'd0;
      error_q     <= 1'b0;
      len_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
      len_bad_q   <= len_bad_d;
    end
  end

endmodule
